// File: rtl/max30003_ecg_reader.sv
// MAX30003 command sequencer: power-up init, periodic ECG FIFO polling and drain,
// overflow recovery via FIFO reset. Drives a 32-bit SPI master one frame at a time.
module max30003_ecg_reader #(
  parameter int unsigned POLL_DIV     = 100000,
  parameter int unsigned PWRUP_CYCLES = 1000,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned MAX_DRAIN    = 32,
  parameter logic [23:0] CFG_GEN      = 24'h081007,
  parameter logic [23:0] CFG_EMUX     = 24'h000000,
  parameter logic [23:0] CFG_ECG      = 24'h805000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        spi_start,
  output logic [31:0] spi_tx_data,
  input  logic [31:0] spi_rx_data,
  input  logic        spi_done,
  output logic [17:0] sample_data,
  output logic [2:0]  sample_etag,
  output logic        sample_valid,
  output logic        init_done,
  output logic        fifo_ovf,
  output logic        spi_err,
  input  logic        flag_clear
);

  localparam int PCW = $clog2(POLL_DIV + 1);
  localparam int UCW = $clog2(PWRUP_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(MAX_DRAIN + 1);
  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_DIV - 1);
  localparam logic [UCW-1:0] PWR_LAST   = UCW'(PWRUP_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MAX_DRAIN - 1);

  typedef enum logic [3:0] {
    PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, PARSE, FRST_ISSUE, FRST_WAIT
  } state_t;

  state_t         state, state_n;
  logic [UCW-1:0] pwr_cnt, pwr_cnt_n;
  logic [TCW-1:0] wait_cnt, wait_cnt_n;
  logic [PCW-1:0] poll_cnt, poll_cnt_n;
  logic           poll_pend, poll_pend_n;
  logic [DCW-1:0] drain_cnt, drain_cnt_n;
  logic [2:0]     init_idx, init_idx_n;
  logic [20:0]    rx_q, rx_n;  // rx[23:3]: sample in [20:3], ETAG in [2:0]
  logic           start_n, svalid_n, init_done_n, ovf_set, err_set;
  logic [31:0]    tx_n;
  logic [17:0]    sdata_n;
  logic [2:0]     setag_n;
  logic           poll_run, poll_tick;
  logic           unused_rx;

  assign unused_rx = ^{spi_rx_data[31:24], spi_rx_data[2:0]};

  function automatic logic [31:0] init_frame(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'h1000_0000;
      3'd1:    return {8'h20, CFG_GEN};
      3'd2:    return {8'h28, CFG_EMUX};
      3'd3:    return {8'h2A, CFG_ECG};
      default: return 32'h1200_0000;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    pwr_cnt_n   = pwr_cnt;
    wait_cnt_n  = wait_cnt;
    poll_cnt_n  = poll_cnt;
    poll_pend_n = poll_pend;
    drain_cnt_n = drain_cnt;
    init_idx_n  = init_idx;
    rx_n        = rx_q;
    start_n     = 1'b0;
    tx_n        = spi_tx_data;
    sdata_n     = sample_data;
    setag_n     = sample_etag;
    svalid_n    = 1'b0;
    init_done_n = init_done;
    ovf_set     = 1'b0;
    err_set     = 1'b0;

    // Poll timebase free-runs while enabled so poll starts stay POLL_DIV apart
    // regardless of read duration; a wrap seen while busy is remembered.
    poll_run  = init_done && enable;
    poll_tick = poll_run && (poll_cnt == POLL_LAST);
    if (!poll_run || poll_tick) poll_cnt_n = '0;
    else                        poll_cnt_n = poll_cnt + 1'b1;
    if (!enable)                         poll_pend_n = 1'b0;
    else if (poll_tick && state != IDLE) poll_pend_n = 1'b1;

    case (state)
      PWRUP: begin
        if (pwr_cnt == PWR_LAST) begin
          state_n    = INIT_ISSUE;
          init_idx_n = '0;
        end else begin
          pwr_cnt_n = pwr_cnt + 1'b1;
        end
      end
      INIT_ISSUE: begin
        start_n    = 1'b1;
        tx_n       = init_frame(init_idx);
        wait_cnt_n = '0;
        state_n    = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (spi_done) begin
          if (init_idx == 3'd4) begin
            init_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            init_idx_n = init_idx + 1'b1;
            state_n    = INIT_ISSUE;
          end
        end else if (wait_cnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = INIT_ISSUE;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (enable && (poll_tick || poll_pend)) begin
          state_n     = RD_ISSUE;
          drain_cnt_n = '0;
          poll_pend_n = 1'b0;
        end
      end
      RD_ISSUE: begin
        start_n    = 1'b1;
        tx_n       = 32'h4300_0000;
        wait_cnt_n = '0;
        state_n    = RD_WAIT;
      end
      RD_WAIT: begin
        if (spi_done) begin
          rx_n    = spi_rx_data[23:3];
          state_n = PARSE;
        end else if (wait_cnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      PARSE: begin
        state_n = IDLE;
        case (rx_q[2:0])
          3'b000, 3'b001: begin
            svalid_n    = 1'b1;
            drain_cnt_n = drain_cnt + 1'b1;
            if (drain_cnt < DRAIN_LAST && enable) state_n = RD_ISSUE;
          end
          3'b010, 3'b011: svalid_n = 1'b1;
          3'b111: begin
            ovf_set = 1'b1;
            state_n = FRST_ISSUE;
          end
          default: ;
        endcase
        if (svalid_n) begin
          sdata_n = rx_q[20:3];
          setag_n = rx_q[2:0];
        end
      end
      FRST_ISSUE: begin
        start_n    = 1'b1;
        tx_n       = 32'h1400_0000;
        wait_cnt_n = '0;
        state_n    = FRST_WAIT;
      end
      FRST_WAIT: begin
        if (spi_done) begin
          state_n = IDLE;
        end else if (wait_cnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PWRUP;
      pwr_cnt      <= '0;
      wait_cnt     <= '0;
      poll_cnt     <= '0;
      poll_pend    <= 1'b0;
      drain_cnt    <= '0;
      init_idx     <= '0;
      rx_q         <= '0;
      spi_start    <= 1'b0;
      spi_tx_data  <= '0;
      sample_data  <= '0;
      sample_etag  <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      fifo_ovf     <= 1'b0;
      spi_err      <= 1'b0;
    end else begin
      state        <= state_n;
      pwr_cnt      <= pwr_cnt_n;
      wait_cnt     <= wait_cnt_n;
      poll_cnt     <= poll_cnt_n;
      poll_pend    <= poll_pend_n;
      drain_cnt    <= drain_cnt_n;
      init_idx     <= init_idx_n;
      rx_q         <= rx_n;
      spi_start    <= start_n;
      spi_tx_data  <= tx_n;
      sample_data  <= sdata_n;
      sample_etag  <= setag_n;
      sample_valid <= svalid_n;
      init_done    <= init_done_n;
      fifo_ovf     <= ovf_set | (fifo_ovf & ~flag_clear);
      spi_err      <= err_set | (spi_err & ~flag_clear);
    end
  end

endmodule

// File: tb/tb_max30003_ecg_reader.sv
// Directed bench for max30003_ecg_reader with a behavioural SPI slave that answers
// each frame a fixed latency after spi_start.
module tb_max30003_ecg_reader;
  localparam int unsigned POLL_DIV = 3000;
  localparam int unsigned PWRUP    = 20;
  localparam int unsigned TMO      = 200;
  localparam int          LAT      = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flag_clear = 1'b0;
  logic        spi_start, spi_done;
  logic [31:0] spi_tx_data, spi_rx_data;
  logic [17:0] sample_data;
  logic [2:0]  sample_etag;
  logic        sample_valid, init_done, fifo_ovf, spi_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sv_count = 0;
  int last_done = -1;
  logic        mute = 1'b0;
  logic        aborted;
  logic [31:0] model_rsp;
  logic [31:0] frame_q[$];
  int          fcyc_q[$];
  logic [31:0] resp_q[$];

  logic [31:0] f;
  int c, s1, s2, s3, s4, s5, s6, vc, sv0, nreads, n;
  logic [31:0] init_exp [5] = '{32'h1000_0000, 32'h2008_1007, 32'h2800_0000,
                                32'h2A80_5000, 32'h1200_0000};

  max30003_ecg_reader #(
    .POLL_DIV(POLL_DIV), .PWRUP_CYCLES(PWRUP), .TIMEOUT(TMO), .MAX_DRAIN(32),
    .CFG_GEN(24'h081007), .CFG_EMUX(24'h000000), .CFG_ECG(24'h805000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
    .spi_done(spi_done), .sample_data(sample_data), .sample_etag(sample_etag),
    .sample_valid(sample_valid), .init_done(init_done), .fifo_ovf(fifo_ovf),
    .spi_err(spi_err), .flag_clear(flag_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_valid === 1'b1) sv_count <= sv_count + 1;

  // SPI slave: logs each frame, answers LAT cycles later unless muted or reset.
  initial begin
    spi_done = 1'b0;
    spi_rx_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start === 1'b1) begin
        frame_q.push_back(spi_tx_data);
        fcyc_q.push_back(cyc);
        model_rsp = 32'h0000_0030;
        if (spi_tx_data[24] && resp_q.size() > 0) model_rsp = resp_q.pop_front();
        if (!mute) begin
          aborted = 1'b0;
          for (int i = 0; i < LAT && !aborted; i++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
          if (!aborted) begin
            spi_rx_data = model_rsp;
            spi_done = 1'b1;
            last_done = cyc;
            @(negedge clk);
            spi_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag, input int limit, output logic [31:0] fr, output int fc);
    int k = 0;
    while (frame_q.size() == 0 && k < limit) begin tick(); k++; end
    chk({tag, "_arrived"}, 32'(frame_q.size() != 0), 1);
    if (frame_q.size() != 0) begin
      fr = frame_q.pop_front();
      fc = fcyc_q.pop_front();
    end else begin
      fr = 'x;
      fc = -1;
    end
  endtask

  task automatic wait_valid(input string tag, input int limit, output int vcy);
    int k = 0;
    while (sample_valid !== 1'b1 && k < limit) begin tick(); k++; end
    chk({tag, "_arrived"}, 32'(sample_valid), 1);
    vcy = cyc;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_start"}, 32'(spi_start), 0);
    chk({tag, "_tx"}, spi_tx_data, 0);
    chk({tag, "_sdata"}, 32'(sample_data), 0);
    chk({tag, "_etag"}, 32'(sample_etag), 0);
    chk({tag, "_svalid"}, 32'(sample_valid), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_ovf"}, 32'(fifo_ovf), 0);
    chk({tag, "_err"}, 32'(spi_err), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_values("rst");
    rst_n = 1'b1;

    // Init sequence with enable low
    for (int i = 0; i < 5; i++) begin
      wait_frame($sformatf("init%0d", i), PWRUP + 200, f, c);
      chk($sformatf("init_frame%0d", i), f, init_exp[i]);
    end
    n = 0;
    while (spi_done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("init_last_done", 32'(spi_done), 1);
    chk("init_done_pre", 32'(init_done), 0);
    tick();
    chk("init_done_post", 32'(init_done), 1);

    // Two-sample drain: valid then valid-EOF
    resp_q.push_back(32'h00FF_FFC0);
    resp_q.push_back(32'h0004_0010);
    enable = 1'b1;
    wait_frame("poll1", POLL_DIV + 50, f, s1);
    chk("poll1_frame", f, 32'h4300_0000);
    wait_valid("samp1", 200, vc);
    chk("samp1_data", 32'(sample_data), 32'h3FFFF);
    chk("samp1_etag", 32'(sample_etag), 0);
    chk("samp1_latency", 32'(vc - last_done), 2);
    tick();
    chk("samp1_pulse", 32'(sample_valid), 0);
    chk("samp1_hold", 32'(sample_data), 32'h3FFFF);
    wait_frame("reread", 50, f, c);
    chk("reread_frame", f, 32'h4300_0000);
    chk("reread_gap", 32'(c - last_done), 3);
    wait_valid("samp2", 200, vc);
    chk("samp2_data", 32'(sample_data), 32'h01000);
    chk("samp2_etag", 32'(sample_etag), 2);

    // Empty FIFO: no strobe, next poll on the POLL_DIV grid
    sv0 = sv_count;
    wait_frame("poll2", POLL_DIV, f, s2);
    chk("poll2_frame", f, 32'h4300_0000);
    chk("poll2_interval", 32'(s2 - s1), POLL_DIV);
    resp_q.push_back(32'h0000_0038);
    repeat (LAT + 10) tick();
    chk("empty_nostrobe", 32'(sv_count - sv0), 0);

    // Overflow: FIFO reset frame, sticky flag, clear
    wait_frame("poll3", POLL_DIV, f, s3);
    chk("poll3_interval", 32'(s3 - s2), POLL_DIV);
    wait_frame("frst", LAT + 20, f, c);
    chk("frst_frame", f, 32'h1400_0000);
    chk("ovf_set", 32'(fifo_ovf), 1);
    chk("ovf_nostrobe", 32'(sv_count - sv0), 0);
    flag_clear = 1'b1;
    tick();
    flag_clear = 1'b0;
    chk("ovf_clear", 32'(fifo_ovf), 0);
    repeat (LAT + 10) tick();

    // Read timeout
    mute = 1'b1;
    wait_frame("poll4", POLL_DIV, f, s4);
    chk("poll4_interval", 32'(s4 - s3), POLL_DIV);
    while (cyc < s4 + int'(TMO) - 1) tick();
    chk("err_before_timeout", 32'(spi_err), 0);
    tick();
    chk("err_at_timeout", 32'(spi_err), 1);
    mute = 1'b0;
    wait_frame("poll5", POLL_DIV, f, s5);
    chk("poll5_frame", f, 32'h4300_0000);
    chk("poll5_interval", 32'(s5 - s4), POLL_DIV);
    flag_clear = 1'b1;
    tick();
    flag_clear = 1'b0;
    chk("err_clear", 32'(spi_err), 0);

    // Continuous valid ETAG: drain stops at 32 reads
    for (int i = 1; i <= 40; i++) resp_q.push_back(32'(i * 64 + 8));
    sv0 = sv_count;
    wait_frame("poll6", POLL_DIV, f, s6);
    chk("poll6_interval", 32'(s6 - s5), POLL_DIV);
    nreads = 1;
    while (cyc < s6 + int'(POLL_DIV) - 20) begin
      tick();
      while (frame_q.size() > 0) begin
        void'(frame_q.pop_front());
        void'(fcyc_q.pop_front());
        nreads++;
      end
    end
    chk("drain_reads", 32'(nreads), 32);
    chk("drain_strobes", 32'(sv_count - sv0), 32);
    chk("drain_last_data", 32'(sample_data), 32);
    chk("drain_last_etag", 32'(sample_etag), 1);
    resp_q.delete();

    // Reset during RD_WAIT, then init restarts
    wait_frame("poll7", 40, f, c);
    chk("poll7_frame", f, 32'h4300_0000);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_values("midrst");
    frame_q.delete();
    fcyc_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_frame("reinit", PWRUP + LAT + 100, f, c);
    chk("reinit_frame", f, 32'h1000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/max30003_ecg_reader.md
Name: max30003_ecg_reader

Overview:
Command sequencer that sits directly upstream of the 32-bit SPI master in the ECG front end, and consumes its received words. After reset it programs the MAX30003 with a fixed init sequence. It then polls the ECG FIFO at a fixed rate, drains valid samples and reports each one as a single-cycle strobe. FIFO overflow is handled with a FIFO reset.

Parameters:
POLL_DIV, 100000, clk cycles between FIFO polls (1 kHz at 100 MHz)
PWRUP_CYCLES, 1000, idle cycles after reset before first SPI frame
TIMEOUT, 4096, max clk cycles from spi_start to spi_done before abort
MAX_DRAIN, 32, max back-to-back FIFO reads per poll
CFG_GEN, 24'h081007, CNFG_GEN (0x10) write data
CFG_EMUX, 24'h000000, CNFG_EMUX (0x14) write data
CFG_ECG, 24'h805000, CNFG_ECG (0x15) write data

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  polling enable; level
spi_start  out  1  one-cycle transfer request to SPI master
spi_tx_data  out  32  frame: {addr[6:0], rw(1=read), data[23:0]}
spi_rx_data  in  32  received frame; data in [23:0]
spi_done  in  1  one-cycle transfer-complete strobe
sample_data  out  18  signed ECG sample, rx[23:6]
sample_etag  out  3  ETAG of sample, rx[5:3]
sample_valid  out  1  one-cycle strobe, sample_data/etag valid this cycle
init_done  out  1  high once init sequence completes; stays high
fifo_ovf  out  1  sticky overflow flag
spi_err  out  1  sticky transfer-timeout flag
flag_clear  in  1  synchronous clear of fifo_ovf and spi_err

Behaviour:
- Clock and reset: single clock domain; rst_n is async assert, sync deassert (external). Reset mid-transfer aborts immediately; no completion is awaited.
- Reset values: spi_start=0, spi_tx_data=0, sample_data=0, sample_etag=0, sample_valid=0, init_done=0, fifo_ovf=0, spi_err=0; state=PWRUP, counters=0.
- States: PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, PARSE, FRST_ISSUE, FRST_WAIT.
- PWRUP: counts PWRUP_CYCLES, then goes to INIT_ISSUE with index 0.
- Init sequence, fixed order, all writes, each as ISSUE then WAIT:
  - SW_RST 0x08 data 0 -> 32'h1000_0000
  - CNFG_GEN -> {8'h20, CFG_GEN}
  - CNFG_EMUX -> {8'h28, CFG_EMUX}
  - CNFG_ECG -> {8'h2A, CFG_ECG}
  - SYNCH 0x09 data 0 -> 32'h1200_0000
  - After the SYNCH spi_done: init_done<=1, go to IDLE. The init sequence runs regardless of enable.
- SPI handshake:
  - In ISSUE states, spi_tx_data is driven and spi_start pulses for exactly one cycle; next state is WAIT.
  - spi_tx_data is held stable until spi_done.
  - At most one outstanding transfer; the next spi_start comes no earlier than the cycle after spi_done.
- Timeout: any WAIT state counts cycles. At TIMEOUT without spi_done: spi_err<=1, go to IDLE (or restart INIT_ISSUE at the same index if init_done=0).
- IDLE: the poll counter increments only while enable=1. At POLL_DIV-1 it resets to 0, drain count clears, and the FSM goes to RD_ISSUE. With enable=0 the counter holds at 0.
- RD_ISSUE: tx = 32'h4300_0000 (ECG_FIFO 0x21, read). RD_WAIT captures spi_rx_data on spi_done, then goes to PARSE (one cycle).
- PARSE, decoded on ETAG = rx[5:3]:
  - 000 / 001 (valid / fast): sample_valid=1. Re-read immediately (RD_ISSUE) if drain count < MAX_DRAIN-1 and enable=1; otherwise go to IDLE. Drain count increments.
  - 010 / 011 (valid EOF): sample_valid=1, go to IDLE.
  - 110 (empty): no strobe, go to IDLE.
  - 111 (overflow): no strobe, fifo_ovf<=1, go to FRST_ISSUE.
  - 100 / 101 (reserved): no strobe, go to IDLE.
- FRST_ISSUE: write FIFO_RST 0x0A -> 32'h1400_0000, then FRST_WAIT, then IDLE.
- sample_data and sample_etag update only on the cycle sample_valid is high and hold otherwise. sample_data is rx[23:6] verbatim (two's complement).
- enable falling mid-read: the current transfer completes and its sample is still reported; no further read is issued.
- Flags: flag_clear clears the flags. If set and clear occur in the same cycle, set wins.
- Latency: sample_valid occurs 2 cycles after the spi_done of its read.

Test Plan:
1. Reset release, SPI model returns done 60 cycles after each start -> five frames in order: 1000_0000, 2008_1007, 2800_0000, 2A80_5000, 1200_0000; init_done rises the cycle after the 5th spi_done.
2. enable=1, rx=32'h00FF_FFC0 then 32'h0004_0010 -> first strobe sample_data=18'h3FFFF, etag=0, immediate re-read; second strobe sample_data=18'h01000, etag=2; FSM then idles until the next POLL_DIV boundary.
3. rx=32'h0000_0030 (empty) -> no sample_valid, next read issued exactly POLL_DIV cycles after the previous poll.
4. rx=32'h0000_0038 -> fifo_ovf=1, next frame 32'h1400_0000; flag_clear pulse -> fifo_ovf=0.
5. Model never asserts spi_done during a read -> spi_err=1 after TIMEOUT cycles, FSM back in IDLE; polling resumes.
6. rst_n low mid-RD_WAIT, then released -> all outputs reset values, init sequence restarts from SW_RST; also check continuous valid ETAG stops after MAX_DRAIN=32 reads.
